// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_predictor
//  Purpose  : Tagged branch target buffer with saturating direction counters.
//             Looked up with the fetch PC (registered prediction next cycle),
//             trained with resolved branches through a two-stage update path,
//             and cleared by a hardware sweep after every reset.
//  Ports    : clk, rst (sync, active-low)
//             init_busy                          - clear sweep in progress
//             lk_en, lk_pc                       - lookup request
//             pred_hit, pred_taken, pred_target  - registered prediction
//             upd_en, upd_pc, upd_branch,
//             upd_taken, upd_target              - resolved instruction
//  Revision : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
  parameter int PC_W     = 32,
  parameter int IDX_W    = 10,
  parameter int TAG_W    = 8,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            init_busy,
  input  logic            lk_en,
  input  logic [PC_W-1:0] lk_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_branch,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int DEPTH = 1 << IDX_W;
  // Untagged configurations still keep a 1-bit tag tied to zero so every
  // compare succeeds and no zero-width vectors appear.
  localparam int TAG_S = (TAG_W > 0) ? TAG_W : 1;

  localparam logic [CTR_W-1:0] c_ctr_max  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] c_ctr_init = CTR_W'(CTR_INIT);
  localparam logic [PC_W-1:0]  c_pc_step  = PC_W'(4);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Table storage
  logic             r_mem_valid [DEPTH];
  logic [TAG_S-1:0] r_mem_tag   [DEPTH];
  logic [CTR_W-1:0] r_mem_ctr   [DEPTH];
  logic [PC_W-1:0]  r_mem_tgt   [DEPTH];

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_sweep;
  logic             w_sweep_last;

  logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
  logic [TAG_S-1:0] w_lk_tag, w_upd_tag;
  logic             w_unused_pc;

  // Single write port, shared by the clear sweep and the U2 stage
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_wr_valid;
  logic [TAG_S-1:0] w_wr_tag;
  logic [CTR_W-1:0] w_wr_ctr;
  logic [PC_W-1:0]  w_wr_tgt;

  // U1 stage: captured update plus the entry it read
  logic             r_u1_vld, r_u1_branch, r_u1_taken;
  logic [IDX_W-1:0] r_u1_idx;
  logic [TAG_S-1:0] r_u1_tag;
  logic [PC_W-1:0]  r_u1_tgt;
  logic             r_u1_evalid;
  logic [TAG_S-1:0] r_u1_etag;
  logic [CTR_W-1:0] r_u1_ectr;
  logic [PC_W-1:0]  r_u1_etgt;
  logic             w_u1_hit;

  // Read ports after write-first bypass
  logic             w_lk_bp, w_upd_bp;
  logic             w_lk_valid, w_upd_valid;
  logic [TAG_S-1:0] w_lk_etag, w_upd_etag;
  logic [CTR_W-1:0] w_lk_ctr, w_upd_ctr;
  logic [PC_W-1:0]  w_lk_tgt, w_upd_tgt;
  logic             w_lk_hit, w_lk_taken;
  logic [PC_W-1:0]  w_lk_seq;

  assign w_lk_idx    = lk_pc[2 +: IDX_W];
  assign w_upd_idx   = upd_pc[2 +: IDX_W];
  assign w_unused_pc = ^upd_pc;

  generate
    if (TAG_W > 0) begin : g_tagged
      assign w_lk_tag  = lk_pc[2+IDX_W +: TAG_S];
      assign w_upd_tag = upd_pc[2+IDX_W +: TAG_S];
    end else begin : g_untagged
      assign w_lk_tag  = '0;
      assign w_upd_tag = '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_sweep <= r_sweep + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sweep_last = 1'b0;
    init_busy    = !rst || (r_state == ST_INIT);
    if (r_state == ST_INIT && (&r_sweep)) begin
      w_sweep_last = 1'b1;
      w_state_next = ST_READY;
    end
  end

  // --------------------------------------------------------------------------
  // U2: compute the new entry from the U1 snapshot and drive the write port
  // --------------------------------------------------------------------------
  assign w_u1_hit = r_u1_evalid && (r_u1_etag == r_u1_tag);

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_idx   = r_u1_idx;
    w_wr_valid = r_u1_evalid;
    w_wr_tag   = r_u1_etag;
    w_wr_ctr   = r_u1_ectr;
    w_wr_tgt   = r_u1_etgt;
    if (!rst) begin
      w_wr_en = 1'b0;               // reset edge: in-flight update is dropped
    end else if (r_state == ST_INIT) begin
      w_wr_en    = 1'b1;
      w_wr_idx   = r_sweep;
      w_wr_valid = 1'b0;
    end else if (r_u1_vld) begin
      if (!r_u1_branch) begin
        // A non-branch that hits is an alias; kill the entry.
        w_wr_en    = w_u1_hit;
        w_wr_valid = 1'b0;
      end else if (w_u1_hit) begin
        w_wr_en    = 1'b1;
        w_wr_valid = 1'b1;
        if (r_u1_taken) begin
          w_wr_ctr = (r_u1_ectr == c_ctr_max) ? c_ctr_max : r_u1_ectr + 1'b1;
          w_wr_tgt = r_u1_tgt;
        end else begin
          w_wr_ctr = (r_u1_ectr == '0) ? '0 : r_u1_ectr - 1'b1;
        end
      end else if (r_u1_taken) begin
        w_wr_en    = 1'b1;
        w_wr_valid = 1'b1;
        w_wr_tag   = r_u1_tag;
        w_wr_ctr   = c_ctr_init;
        w_wr_tgt   = r_u1_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem_valid[w_wr_idx] <= w_wr_valid;
      r_mem_tag[w_wr_idx]   <= w_wr_tag;
      r_mem_ctr[w_wr_idx]   <= w_wr_ctr;
      r_mem_tgt[w_wr_idx]   <= w_wr_tgt;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Both see the entry being written on the same edge, which
  // gives the lookup its write-first behaviour and gives back-to-back
  // updates to one index an up-to-date counter.
  // --------------------------------------------------------------------------
  assign w_lk_bp    = w_wr_en && (w_wr_idx == w_lk_idx);
  assign w_lk_valid = w_lk_bp ? w_wr_valid : r_mem_valid[w_lk_idx];
  assign w_lk_etag  = w_lk_bp ? w_wr_tag   : r_mem_tag[w_lk_idx];
  assign w_lk_ctr   = w_lk_bp ? w_wr_ctr   : r_mem_ctr[w_lk_idx];
  assign w_lk_tgt   = w_lk_bp ? w_wr_tgt   : r_mem_tgt[w_lk_idx];

  assign w_upd_bp    = w_wr_en && (w_wr_idx == w_upd_idx);
  assign w_upd_valid = w_upd_bp ? w_wr_valid : r_mem_valid[w_upd_idx];
  assign w_upd_etag  = w_upd_bp ? w_wr_tag   : r_mem_tag[w_upd_idx];
  assign w_upd_ctr   = w_upd_bp ? w_wr_ctr   : r_mem_ctr[w_upd_idx];
  assign w_upd_tgt   = w_upd_bp ? w_wr_tgt   : r_mem_tgt[w_upd_idx];

  assign w_lk_hit   = w_lk_valid && (w_lk_etag == w_lk_tag);
  assign w_lk_taken = w_lk_hit && w_lk_ctr[CTR_W-1];
  assign w_lk_seq   = lk_pc + c_pc_step;

  // U1 capture; the edge that finishes the sweep already accepts updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_u1_vld <= 1'b0;
    end else begin
      r_u1_vld <= upd_en && (r_state == ST_READY || w_sweep_last);
    end
    r_u1_branch <= upd_branch;
    r_u1_taken  <= upd_taken;
    r_u1_idx    <= w_upd_idx;
    r_u1_tag    <= w_upd_tag;
    r_u1_tgt    <= upd_target;
    r_u1_evalid <= w_upd_valid;
    r_u1_etag   <= w_upd_etag;
    r_u1_ectr   <= w_upd_ctr;
    r_u1_etgt   <= w_upd_tgt;
  end

  // Registered prediction; forced miss until the sweep has finished.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (lk_en) begin
      if (r_state != ST_READY) begin
        pred_hit    <= 1'b0;
        pred_taken  <= 1'b0;
        pred_target <= w_lk_seq;
      end else begin
        pred_hit    <= w_lk_hit;
        pred_taken  <= w_lk_taken;
        pred_target <= w_lk_taken ? w_lk_tgt : w_lk_seq;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_target_predictor
//  Purpose  : Directed self-checking bench for branch_target_predictor with
//             IDX_W=4 (index = pc[5:2], tag = pc[13:6]), CTR_W=2, CTR_INIT=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_busy;
  logic        lk_en;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_branch;
  logic        upd_taken;
  logic [31:0] upd_target;

  int checks = 0;
  int errors = 0;
  int n;

  branch_target_predictor #(
    .PC_W(32), .IDX_W(4), .TAG_W(8), .CTR_W(2), .CTR_INIT(2)
  ) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .lk_en(lk_en), .lk_pc(lk_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_branch(upd_branch),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pred(input string tag, input logic h, input logic t, input logic [31:0] tgt);
    chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, h});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
    chk({tag, "_target"}, pred_target, tgt);
  endtask

  // One update sampled on the next edge; written on the edge after.
  task automatic do_upd(input logic [31:0] pc, input logic br, input logic tk,
                        input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = pc; upd_branch = br; upd_taken = tk; upd_target = tgt;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic do_lk(input logic [31:0] pc);
    lk_en = 1'b1; lk_pc = pc;
    tick();
    lk_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; lk_en = 1'b1; lk_pc = 32'h100;
    upd_en = 1'b0; upd_pc = '0; upd_branch = 1'b0; upd_taken = 1'b0; upd_target = '0;

    // Reset held for three edges
    repeat (3) tick();
    chk("rst_busy", {31'd0, init_busy}, 32'd1);
    chk_pred("rst", 1'b0, 1'b0, 32'h0);

    // First sweep: forced-miss lookup, updates during INIT are ignored
    rst = 1'b1;
    upd_en = 1'b1; upd_pc = 32'h44; upd_branch = 1'b1; upd_taken = 1'b1; upd_target = 32'h300;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk_pred("sweep_lk", 1'b0, 1'b0, 32'h104);
      if (n == 5) upd_en = 1'b0;
    end while (init_busy && n < 100);
    chk("sweep_len", n, 32'd16);
    lk_en = 1'b0;
    tick();
    do_lk(32'h44);
    chk_pred("init_upd_ignored", 1'b0, 1'b0, 32'h48);

    // Allocate and predict
    do_upd(32'h40, 1'b1, 1'b1, 32'h80);
    tick();
    do_lk(32'h40);
    chk_pred("alloc", 1'b1, 1'b1, 32'h80);
    do_lk(32'h80);
    chk_pred("tag_miss", 1'b0, 1'b0, 32'h84);

    // Hysteresis: 2 -> 1 -> 0, then saturate at 0
    do_upd(32'h40, 1'b1, 1'b0, 32'h0);
    do_upd(32'h40, 1'b1, 1'b0, 32'h0);
    tick();
    do_lk(32'h40);
    chk_pred("nt2", 1'b1, 1'b0, 32'h44);
    do_upd(32'h40, 1'b1, 1'b0, 32'h0);
    tick();
    do_lk(32'h40);
    chk_pred("nt_sat0", 1'b1, 1'b0, 32'h44);

    // Four back-to-back taken: 0 -> 1 -> 2 -> 3 -> 3
    repeat (4) do_upd(32'h40, 1'b1, 1'b1, 32'h90);
    tick();
    do_lk(32'h40);
    chk_pred("t4", 1'b1, 1'b1, 32'h90);
    do_upd(32'h40, 1'b1, 1'b0, 32'h0);
    tick();
    do_lk(32'h40);
    chk_pred("sat3_nt1", 1'b1, 1'b1, 32'h90);
    do_upd(32'h40, 1'b1, 1'b0, 32'h0);
    tick();
    do_lk(32'h40);
    chk_pred("sat3_nt2", 1'b1, 1'b0, 32'h44);

    // Aliased non-branch invalidates the entry
    do_upd(32'h40, 1'b0, 1'b0, 32'h0);
    tick();
    do_lk(32'h40);
    chk_pred("alias", 1'b0, 1'b0, 32'h44);

    // Not-taken branch to an empty index allocates nothing
    do_upd(32'h48, 1'b1, 1'b0, 32'h200);
    tick();
    do_lk(32'h48);
    chk_pred("nt_noalloc", 1'b0, 1'b0, 32'h4c);

    // Lookup on the same edge as the allocation write
    do_upd(32'h40, 1'b1, 1'b1, 32'ha0);
    do_lk(32'h40);
    chk_pred("bypass", 1'b1, 1'b1, 32'ha0);

    // Reset while an update sits in U1/U2
    upd_en = 1'b1; upd_pc = 32'h4c; upd_branch = 1'b1; upd_taken = 1'b1; upd_target = 32'hb0;
    tick();
    upd_en = 1'b0;
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", {31'd0, init_busy}, 32'd1);
    chk_pred("mid_rst", 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 15) begin
        // sampled on the edge where init_busy falls
        upd_en = 1'b1; upd_pc = 32'h60; upd_branch = 1'b1; upd_taken = 1'b1;
        upd_target = 32'hc0;
      end
    end while (init_busy && n < 100);
    upd_en = 1'b0;
    chk("sweep2_len", n, 32'd16);
    tick();
    do_lk(32'h60);
    chk_pred("upd_at_ready", 1'b1, 1'b1, 32'hc0);
    do_lk(32'h4c);
    chk_pred("no_stale_write", 1'b0, 1'b0, 32'h50);
    do_lk(32'h40);
    chk_pred("resweep_clear", 1'b0, 1'b0, 32'h44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
